// File: rtl/alu_pipe_hs.sv
// Registered ALU with valid/ready command and result handshakes.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (op 110); otherwise op 110 is illegal.
module alu_pipe_hs #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               equal,
    output logic               greater,
    output logic               lesser,
    output logic               err
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // Sources hold their payload stable until that edge; results are frozen while
    // out_valid is 1 and out_ready is 0.

    localparam int RW = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    logic            out_valid_q, out_valid_d;
    logic [RW-1:0]   result_q, result_d;
    logic            equal_q, equal_d;
    logic            greater_q, greater_d;
    logic            lesser_q, lesser_d;
    logic            err_q, err_d;

    logic            accept;
    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  diff;
    logic [RW-1:0]   alu_res;
    logic            alu_err;

`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  bit_sel;
    logic [RW-1:0]     addend;
    logic              mul_bit;
    logic              mul_last;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign bit_sel  = {{(WIDTH-1){1'b0}}, 1'b1} << cnt_q;
    assign mul_bit  = |(mplier_q & bit_sel);
    assign addend   = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));
`else
    assign in_ready = !out_valid_q || out_ready;
`endif

    assign accept = in_valid && in_ready;
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};

    // Single-cycle ops; anything not listed here (incl. op 110 without the multiplier) is illegal.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op)
            OP_ADD:  alu_res[WIDTH:0]   = sum;
            OP_SUB:  alu_res[WIDTH:0]   = diff;
            OP_CMP:  alu_res            = '0;
            OP_AND:  alu_res[WIDTH-1:0] = a & b;
            OP_OR:   alu_res[WIDTH-1:0] = a | b;
            OP_XOR:  alu_res[WIDTH-1:0] = a ^ b;
            default: alu_err            = 1'b1;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        equal_d     = equal_q;
        greater_d   = greater_q;
        lesser_d    = lesser_q;
        err_d       = err_q;
`ifdef ALU_MUL_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
`endif

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
                state_d  = S_MUL;
                cnt_d    = '0;
                prod_d   = '0;
                mcand_d  = a;
                mplier_d = b;
                err_d    = 1'b0;
            end else
`endif
            begin
                result_d    = alu_res;
                err_d       = alu_err;
                equal_d     = (a == b);
                greater_d   = (a > b);
                lesser_d    = (a < b);
                out_valid_d = 1'b1;
            end
        end

`ifdef ALU_MUL_EN
        // One multiplier bit per cycle; the last iteration publishes the product directly.
        if (state_q == S_MUL) begin
            prod_d = prod_q + (mul_bit ? addend : '0);
            cnt_d  = cnt_q + CNT_W'(1);
            if (mul_last) begin
                result_d    = prod_d;
                equal_d     = (mcand_q == mplier_q);
                greater_d   = (mcand_q > mplier_q);
                lesser_d    = (mcand_q < mplier_q);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            equal_q     <= 1'b0;
            greater_q   <= 1'b0;
            lesser_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            equal_q     <= equal_d;
            greater_q   <= greater_d;
            lesser_q    <= lesser_d;
            err_q       <= err_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign equal     = equal_q;
    assign greater   = greater_q;
    assign lesser    = lesser_q;
    assign err       = err_q;

endmodule
